// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: multi-cycle ALU with iterative unsigned mul/div, valid/ready handshakes and branch flags
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int OPW = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OPW-1:0]   operation_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             lt_o,
    output logic             ltu_o,
    output logic             busy_o
);
    localparam logic [OPW-1:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_AND = 4'b0111, OP_OR = 4'b0110;
    localparam logic [OPW-1:0] OP_XOR = 4'b0100, OP_SLL = 4'b0001, OP_SRL = 4'b0101, OP_SRA = 4'b1101;
    localparam logic [OPW-1:0] OP_SLT = 4'b0010, OP_SLTU = 4'b0011, OP_MUL = 4'b1001, OP_MULHU = 4'b1010;
    localparam logic [OPW-1:0] OP_DIVU = 4'b1011, OP_REMU = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] b_q, hi_q, lo_q, result_q;
    logic [OPW-1:0]   op_q;
    logic [SHW-1:0]   cnt_q;
    logic             zero_q, lt_q, ltu_q;

    logic [WIDTH-1:0] alu, hi_n, lo_n, iter_res, div_rem;
    logic [WIDTH:0]   mul_sum, div_rs;
    logic             accept, iter, slt, sltu, is_mul, div_ge;

    assign in_ready_o  = (state_q == IDLE) & ~reset_i;
    assign out_valid_o = state_q == DONE;
    assign busy_o      = state_q == BUSY;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign lt_o        = lt_q;
    assign ltu_o       = ltu_q;
    assign accept      = in_valid_i & in_ready_o;

    always_comb begin
        slt  = $signed(a_i) < $signed(b_i);
        sltu = a_i < b_i;
        iter = (operation_i == OP_MUL) | (operation_i == OP_MULHU) |
               (((operation_i == OP_DIVU) | (operation_i == OP_REMU)) & (|b_i));
        alu  = '0;
        case (operation_i)
            OP_ADD:  alu = a_i + b_i;
            OP_SUB:  alu = a_i - b_i;
            OP_AND:  alu = a_i & b_i;
            OP_OR:   alu = a_i | b_i;
            OP_XOR:  alu = a_i ^ b_i;
            OP_SLL:  alu = a_i << b_i[SHW-1:0];
            OP_SRL:  alu = a_i >> b_i[SHW-1:0];
            OP_SRA:  alu = $signed(a_i) >>> b_i[SHW-1:0];
            OP_SLT:  alu = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: alu = {{(WIDTH-1){1'b0}}, sltu};
            OP_DIVU: alu = '1;
            OP_REMU: alu = a_i;
            default: alu = '0;
        endcase
    end

    // hi/lo hold {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
    always_comb begin
        is_mul   = (op_q == OP_MUL) | (op_q == OP_MULHU);
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_rs   = {hi_q, lo_q[WIDTH-1]};
        div_ge   = div_rs >= {1'b0, b_q};
        div_rem  = div_rs[WIDTH-1:0] - b_q;
        hi_n     = is_mul ? mul_sum[WIDTH:1] : (div_ge ? div_rem : div_rs[WIDTH-1:0]);
        lo_n     = is_mul ? {mul_sum[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], div_ge};
        iter_res = ((op_q == OP_MUL) | (op_q == OP_DIVU)) ? lo_n : hi_n;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (iter ? BUSY : DONE) : IDLE;
            BUSY:    state_d = (&cnt_q) ? DONE : BUSY;
            DONE:    state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                b_q   <= b_i;
                op_q  <= operation_i;
                hi_q  <= '0;
                lo_q  <= a_i;
                cnt_q <= '0;
                lt_q  <= slt;
                ltu_q <= sltu;
                if (!iter) begin
                    result_q <= alu;
                    zero_q   <= alu == '0;
                end
            end
            if (state_q == BUSY) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + 1'b1;
                if (&cnt_q) begin
                    result_q <= iter_res;
                    zero_q   <= iter_res == '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: directed and randomized checks of alu_seq_muldiv against an arithmetic reference model
module tb_alu_seq_muldiv;
    localparam int W = 32;

    logic         clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic         zero, lt, ltu, busy;
    logic [W-1:0] a, b, result;
    logic [3:0]   op;
    int           n_tests, n_fail;

    alu_seq_muldiv #(.WIDTH(W)) dut (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .operation_i(op), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .zero_o(zero), .lt_o(lt), .ltu_o(ltu), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] prod;
        prod = 64'(x) * 64'(y);
        case (o)
            4'd0:  return x + y;
            4'd8:  return x - y;
            4'd7:  return x & y;
            4'd6:  return x | y;
            4'd4:  return x ^ y;
            4'd1:  return x << y[4:0];
            4'd5:  return x >> y[4:0];
            4'd13: return W'($signed(x) >>> y[4:0]);
            4'd2:  return ($signed(x) < $signed(y)) ? 1 : 0;
            4'd3:  return (x < y) ? 1 : 0;
            4'd9:  return prod[31:0];
            4'd10: return prod[63:32];
            4'd11: return (y == 0) ? '1 : x / y;
            4'd12: return (y == 0) ? x : x % y;
            default: return '0;
        endcase
    endfunction

    // Expects to be called just after a negedge with the DUT idle
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
        logic [W-1:0] exp;
        int lat, busy_cnt, exp_lat;
        exp     = model(o, x, y);
        exp_lat = ((o == 9) || (o == 10) || (((o == 11) || (o == 12)) && y != 0)) ? W + 1 : 1;
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
        lat = 1; busy_cnt = 0;
        while (!out_valid && lat < W + 10) begin
            busy_cnt += busy;
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", o), 64'(lat), 64'(exp_lat));
        check($sformatf("busy_cycles op%0d", o), 64'(busy_cnt), 64'(exp_lat - 1));
        check($sformatf("result op%0d %0h,%0h", o, x, y), 64'(result), 64'(exp));
        check($sformatf("zero op%0d", o), 64'(zero), 64'(exp == 0));
        check($sformatf("lt op%0d", o), 64'(lt), 64'($signed(x) < $signed(y)));
        check($sformatf("ltu op%0d", o), 64'(ltu), 64'(x < y));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; op = 4'($urandom);
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(result), 64'(exp));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int rises;
        logic [3:0] ro;
        logic [W-1:0] ra, rb;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({zero, lt, ltu, busy}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        check("add_const", 64'(result), 64'h8000_0000);
        run_op(4'd8, 32'h1234, 32'h1234, 0);
        run_op(4'd13, 32'h8000_0000, 32'h24, 0);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(4'd10, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(4'd11, 32'h100, 32'd7, 0);
        run_op(4'd12, 32'h100, 32'd7, 0);
        run_op(4'd11, 32'd5, 32'd0, 0);
        run_op(4'd12, 32'd5, 32'd0, 0);
        run_op(4'd14, 32'd5, 32'd9, 0);
        run_op(4'd2, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd3, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'd0, 32'd1, 32'd2, 10);

        in_valid = 1'b1; op = 4'd11; a = 32'hDEAD_BEEF; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_div_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_in_ready_rst", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        rises = 0;
        for (int k = 0; k < W + 8; k++) begin
            rises += out_valid;
            @(negedge clk);
        end
        check("abort_no_out_valid", 64'(rises), 64'd0);
        run_op(4'd0, 32'd2, 32'd3, 0);

        for (int n = 0; n < 80; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 :
                 (($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 40)) : W'($urandom));
            run_op(ro, ra, rb, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
